// File: rtl/core_muldiv_pkg.sv
// structures: shared opcode/state types and word-size constant for the
// multiply/divide unit.
package structures;
    typedef enum logic [2:0] {MULT, MULTU, DIV, DIVU, MTHI, MTLO} md_op_t;
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} md_state_t;
    localparam int WORD_W = 32;
endpackage

// File: rtl/core_muldiv_step.sv
// muldiv_step: one combinational iteration, either an add-shift multiply step
// or a restoring divide step on the {upper, lower} accumulator pair.
module muldiv_step #(
    parameter int WIDTH = 64
) (
    input  logic                 i_div,
    input  logic [2*WIDTH-1:0]   i_acc,
    input  logic [WIDTH-1:0]     i_b,
    output logic [2*WIDTH-1:0]   o_acc
);
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_up;
    logic [WIDTH:0] w_trial;
    logic           w_ge;

    assign w_sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_b} : '0);
    // upper is {remainder, next dividend bit}; a clear MSB after subtracting means it fit
    assign w_up    = i_acc[2*WIDTH-1:WIDTH-1];
    assign w_trial = w_up - {1'b0, i_b};
    assign w_ge    = ~w_trial[WIDTH];
    assign o_acc   = i_div ? {w_ge ? w_trial[WIDTH-1:0] : w_up[WIDTH-1:0], i_acc[WIDTH-2:0], w_ge}
                           : {w_sum, i_acc[WIDTH-1:1]};
endmodule

// File: rtl/core_muldiv.sv
// core_muldiv: iterative signed/unsigned multiply and divide with HI/LO
// registers; magnitudes are iterated, signs applied in a single FIX cycle.
module core_muldiv
    import structures::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  md_op_t           i_op,
    input  logic             i_word,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_flush,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int SH = WIDTH - WORD_W;

    function automatic logic [WIDTH-1:0] ext32(input logic [WIDTH-1:0] x, input logic s);
        logic signed [WIDTH-1:0] t;
        t = $signed(x << SH) >>> SH;
        return s ? t : (x << SH) >> SH;
    endfunction

    md_state_t          r_state;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b, r_hi, r_lo;
    logic               r_div, r_word, r_neg_q, r_neg_r, r_dz;

    logic               w_sgn, w_div, w_md, w_sa, w_sb;
    logic [WIDTH-1:0]   w_a_ext, w_b_ext, w_ma, w_mb;
    logic [2*WIDTH-1:0] w_step, w_pmag, w_prod;
    logic [WIDTH-1:0]   w_q, w_r, w_hi, w_lo, w_hi_c, w_lo_c;

    assign w_sgn   = (i_op == MULT) | (i_op == DIV);
    assign w_div   = (i_op == DIV) | (i_op == DIVU);
    assign w_md    = w_div | (i_op == MULT) | (i_op == MULTU);
    assign w_a_ext = i_word ? ext32(i_a, w_sgn) : i_a;
    assign w_b_ext = i_word ? ext32(i_b, w_sgn) : i_b;
    assign w_sa    = w_sgn & w_a_ext[WIDTH-1];
    assign w_sb    = w_sgn & w_b_ext[WIDTH-1];
    // abs(MIN) wraps to MIN, which read unsigned is the correct magnitude
    assign w_ma    = w_sa ? -w_a_ext : w_a_ext;
    assign w_mb    = w_sb ? -w_b_ext : w_b_ext;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_div (r_div),
        .i_acc (r_acc),
        .i_b   (r_b),
        .o_acc (w_step)
    );

    // a 32-step multiply leaves the product 32 bits above where a full run would
    assign w_pmag = r_word ? r_acc >> SH : r_acc;
    assign w_prod = r_neg_q ? -w_pmag : w_pmag;
    assign w_q    = r_dz ? '1 : r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_r    = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    assign w_hi   = r_div ? w_r : r_word ? w_prod[WIDTH-1:0] >> WORD_W : w_prod[2*WIDTH-1:WIDTH];
    assign w_lo   = r_div ? w_q : w_prod[WIDTH-1:0];
    assign w_hi_c = r_word ? ext32(w_hi, 1'b1) : w_hi;
    assign w_lo_c = r_word ? ext32(w_lo, 1'b1) : w_lo;

    assign o_busy = i_reset & ((r_state == IDLE & i_start & w_md & ~i_flush) |
                               r_state == RUN | r_state == FIX);
    assign o_done = r_state == DONE;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_b     <= '0;
            r_div   <= 1'b0;
            r_word  <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (i_flush) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start && w_md) begin
                        r_acc   <= {{WIDTH{1'b0}}, w_div ? (i_word ? w_ma << SH : w_ma) : w_mb};
                        r_b     <= w_div ? w_mb : w_ma;
                        r_div   <= w_div;
                        r_word  <= i_word;
                        r_neg_q <= w_sa ^ w_sb;
                        r_neg_r <= w_sa;
                        r_dz    <= w_div & (w_mb == '0);
                        r_cnt   <= i_word ? CW'(WORD_W) : CW'(WIDTH);
                        r_state <= RUN;
                    end else if (i_start && i_op == MTHI) begin
                        r_hi <= i_a;
                    end else if (i_start && i_op == MTLO) begin
                        r_lo <= i_a;
                    end
                end
                RUN: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1))
                        r_state <= FIX;
                end
                FIX: begin
                    r_hi    <= w_hi_c;
                    r_lo    <= w_lo_c;
                    r_state <= DONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_core_muldiv.sv
// tb_core_muldiv: directed and random MULT/DIV/MTHI/MTLO sequences checked
// against an arithmetic reference model.
module tb_core_muldiv;
    import structures::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        word  = 1'b0;
    logic        flush = 1'b0;
    md_op_t      op    = MULT;
    logic [63:0] a = '0, b = '0;
    logic        busy, done;
    logic [63:0] hi, lo;
    logic [63:0] mhi = '0, mlo = '0;
    int          total = 0, bad = 0;

    core_muldiv #(.WIDTH(64)) dut (
        .i_clock (clock),
        .i_reset (reset),
        .i_start (start),
        .i_op    (op),
        .i_word  (word),
        .i_a     (a),
        .i_b     (b),
        .i_flush (flush),
        .o_busy  (busy),
        .o_done  (done),
        .o_hi    (hi),
        .o_lo    (lo)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] sx32(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    function automatic logic [127:0] model(input md_op_t o, input logic w, input logic [63:0] x, input logic [63:0] y);
        logic               sg;
        logic [63:0]        av, bv, rh, rl;
        logic signed [127:0] sa, sb;
        logic [127:0]       p;
        sg = (o == MULT) || (o == DIV);
        av = w ? (sg ? sx32(x[31:0]) : {32'b0, x[31:0]}) : x;
        bv = w ? (sg ? sx32(y[31:0]) : {32'b0, y[31:0]}) : y;
        if (o == MULT || o == MULTU) begin
            sa = sg ? {{64{av[63]}}, av} : {64'b0, av};
            sb = sg ? {{64{bv[63]}}, bv} : {64'b0, bv};
            p  = sa * sb;
            rh = w ? sx32(p[63:32]) : p[127:64];
            rl = w ? sx32(p[31:0])  : p[63:0];
        end else begin
            if (bv == 0) begin
                rl = '1;
                rh = w ? sx32(x[31:0]) : x;
            end else if (sg && !w && av == 64'h8000_0000_0000_0000 && bv == '1) begin
                rl = av;
                rh = '0;
            end else if (sg) begin
                rl = $signed(av) / $signed(bv);
                rh = $signed(av) % $signed(bv);
            end else begin
                rl = av / bv;
                rh = av % bv;
            end
            if (w) begin
                rh = sx32(rh[31:0]);
                rl = sx32(rl[31:0]);
            end
        end
        return {rh, rl};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input md_op_t o, input logic w, input logic [63:0] x, input logic [63:0] y, input logic now);
        logic [127:0] e;
        int           nb;
        logic         got;
        e = model(o, w, x, y);
        if (!now) @(negedge clock);
        start = 1'b1; op = o; word = w; a = x; b = y;
        nb = 0; got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            #1;
            if (busy) nb++;
            if (done) got = 1'b1;
            else @(negedge clock);
        end
        start = 1'b0;
        chk($sformatf("done_seen op=%s w=%0d", o.name(), w), {127'b0, got}, 128'd1);
        chk($sformatf("busy_cycles op=%s w=%0d", o.name(), w), nb, w ? 34 : 66);
        chk($sformatf("hi op=%s w=%0d a=%h b=%h", o.name(), w, x, y), hi, e[127:64]);
        chk($sformatf("lo op=%s w=%0d a=%h b=%h", o.name(), w, x, y), lo, e[63:0]);
        mhi = e[127:64];
        mlo = e[63:0];
    endtask

    task automatic mt(input md_op_t o, input logic [63:0] x);
        @(negedge clock);
        start = 1'b1; op = o; a = x;
        #1 chk($sformatf("mt_busy %s", o.name()), busy, 0);
        if (o == MTHI) mhi = x; else mlo = x;
    endtask

    initial begin
        #2 reset = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        start = 1'b1; op = MULT;
        #1 chk("rst_busy_forced", busy, 0);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock) reset = 1'b1;

        run_op(MULT, 1'b0, -64'sd3, 64'd7, 1'b0);
        chk("t1_lo_const", lo, 64'hFFFF_FFFF_FFFF_FFEB);
        chk("t1_hi_const", hi, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clock);
        #1 chk("done_one_cycle", done, 0);

        run_op(DIVU, 1'b1, 64'd100, 64'd7, 1'b0);
        chk("t2_lo_const", lo, 64'd14);
        chk("t2_hi_const", hi, 64'd2);
        run_op(MULTU, 1'b1, 64'hFFFF_FFFF, 64'd2, 1'b0);
        chk("t2b_hi_const", hi, 64'd1);
        chk("t2b_lo_const", lo, 64'hFFFF_FFFF_FFFF_FFFE);

        run_op(DIV, 1'b0, -64'sd5, 64'd0, 1'b0);
        chk("t3_lo_const", lo, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t3_hi_const", hi, 64'hFFFF_FFFF_FFFF_FFFB);
        run_op(DIV, 1'b0, 64'h8000_0000_0000_0000, '1, 1'b0);
        chk("t3b_lo_const", lo, 64'h8000_0000_0000_0000);
        chk("t3b_hi_const", hi, 64'd0);

        mt(MTHI, 64'h1234);
        mt(MTLO, 64'h5678);
        #1 chk("mt_hi_visible", hi, 64'h1234);
        @(negedge clock) start = 1'b0;
        #1;
        chk("mt_hi", hi, 64'h1234);
        chk("mt_lo", lo, 64'h5678);

        @(negedge clock);
        start = 1'b1; op = DIV; word = 1'b0; a = 64'd1000; b = 64'd3;
        repeat (10) @(negedge clock);
        flush = 1'b1; start = 1'b0;
        #1 chk("flush_run_busy", busy, 1);
        @(negedge clock) flush = 1'b0;
        start = 1'b1; op = DIVU; a = 64'd77; b = 64'd5;
        #1;
        chk("flush_done", done, 0);
        chk("flush_hi", hi, 64'h1234);
        chk("flush_lo", lo, 64'h5678);
        chk("flush_accept", busy, 1);
        run_op(DIVU, 1'b0, 64'd77, 64'd5, 1'b1);

        @(negedge clock);
        start = 1'b1; op = MULT; word = 1'b0; a = 64'd123; b = 64'd456;
        repeat (5) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("rstrun_busy", busy, 0);
        chk("rstrun_hi", hi, 0);
        chk("rstrun_lo", lo, 0);
        chk("rstrun_done", done, 0);
        start = 1'b0;
        @(negedge clock) reset = 1'b1;
        run_op(MULTU, 1'b0, 64'd6, 64'd7, 1'b0);
        chk("t6_lo_const", lo, 64'd42);
        chk("t6_hi_const", hi, 64'd0);

        for (int i = 0; i < 40; i++) begin
            md_op_t      ro;
            logic        rw;
            logic [63:0] ra, rb;
            int          k;
            ro = md_op_t'($urandom_range(0, 5));
            rw = 1'($urandom_range(0, 1));
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            k  = $urandom_range(0, 7);
            if (k == 0) rb = '0;
            if (k == 1) rb = 64'($urandom_range(1, 20));
            if (k == 2) rb = rw ? 64'hFFFF_FFFF : '1;
            if (k == 3) ra = rw ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
            if (k == 4) begin
                ra = rw ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
                rb = '1;
            end
            if (ro == MTHI || ro == MTLO) begin
                mt(ro, ra);
                @(negedge clock) start = 1'b0;
                #1;
                chk("rnd_mt_hi", hi, mhi);
                chk("rnd_mt_lo", lo, mlo);
            end else begin
                run_op(ro, rw, ra, rb, 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
